cam_capture_ctrl: RTL

//  Frame-level sequencer for the OV7670 capture path feeding the RGB444 frame buffer.

---
 rtl/cam_capture_ctrl_pkg.sv | 27 ++
 rtl/cam_capture_ctrl_sync_edge.sv | 34 +++
 rtl/cam_capture_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_ctrl_pkg.sv
// Shared encodings and defaults for the OV7670 frame capture sequencer.
package cam_capture_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_VS = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE     = 2'd0;
    localparam err_t ERR_LINE_LEN = 2'd1;
    localparam err_t ERR_LINE_CNT = 2'd2;
    localparam err_t ERR_TIMEOUT  = 2'd3;

    localparam int H_PIX_DEF   = 160;
    localparam int V_LINES_DEF = 120;
    localparam int CNT_W_DEF   = 9;
    localparam int TIMEOUT_DEF = 1_000_000;

    // The first fault seen in a frame is the one reported for that frame.
    function automatic err_t err_first(input err_t held, input err_t fresh);
        return (held != ERR_NONE) ? held : fresh;
    endfunction

endpackage

// File: rtl/cam_capture_ctrl_sync_edge.sv
// Two-flop synchronizer for a camera timing signal, plus registered rise/fall pulses.
// level, rise and fall all change in the same cycle, three clocks after the input.
module cam_capture_ctrl_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic dly;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            dly  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            dly  <= sync;
            rise <= sync & ~dly;
            fall <= ~sync & dly;
        end
    end

    assign level = dly;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame sequencer for the OV7670 capture path: arms on request, aligns to vsync,
// gates datapath writes, checks frame geometry and swaps the display banks.
//
// state   | meaning
// IDLE    | waiting for cap_req
// WAIT_VS | armed, waiting for vsync fall (frame start)
// CAPTURE | frame in progress, datapath writes enabled
// DONE    | good frame: swap banks, count it (1 cycle)
// ERROR   | bad frame: banks untouched, err_code held (1 cycle)
module cam_capture_ctrl
    import cam_capture_ctrl_pkg::*;
#(
    parameter int H_PIX   = H_PIX_DEF,
    parameter int V_LINES = V_LINES_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cap_req,
    input  logic       cont,
    input  logic       abort,
    input  logic       CAM_vsync,
    input  logic       CAM_href,
    input  logic       px_wr,
    output logic       cap_en,
    output logic       addr_clr,
    output logic       bank_wr,
    output logic       bank_rd,
    output logic       busy,
    output logic       frame_done,
    output logic [1:0] err_code,
    output logic [7:0] frame_cnt
);

    localparam int               WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] PIX_TGT  = CNT_W'(H_PIX);
    localparam logic [CNT_W-1:0] LINE_TGT = CNT_W'(V_LINES);
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic             vs_lvl;
    logic             vs_rise;
    logic             vs_fall;
    logic             hr_lvl;
    logic             hr_rise;
    logic             hr_fall;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [WD_W-1:0]  wdog;
    err_t             frame_err;
    logic             bank;

    logic wd_active;
    logic timeout;
    logic rearm;
    logic frame_start;
    logic frame_end;
    logic line_bad;
    logic count_bad;
    logic pix_take;

    cam_capture_ctrl_sync_edge u_vs_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (CAM_vsync),
        .level (vs_lvl),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    cam_capture_ctrl_sync_edge u_hr_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (CAM_href),
        .level (hr_lvl),
        .rise  (hr_rise),
        .fall  (hr_fall)
    );

    always_comb begin
        wd_active   = (state == ST_WAIT_VS) || (state == ST_CAPTURE);
        timeout     = wd_active && (wdog == '0);
        rearm       = (state_nx == ST_WAIT_VS) && (state != ST_WAIT_VS);
        frame_start = (state == ST_WAIT_VS) && vs_fall && !abort && !timeout;
        frame_end   = (state == ST_CAPTURE) && vs_rise && !abort && !timeout;
        line_bad    = (state == ST_CAPTURE) && hr_fall && (pix_cnt != PIX_TGT);
        count_bad   = frame_end && (frame_err == ERR_NONE) && (line_cnt != LINE_TGT);
        // Pixels only count inside an active line and outside vertical blanking.
        pix_take    = px_wr && hr_lvl && !vs_lvl && (pix_cnt != CNT_MAX);
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cap_req) state_nx = ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    if (timeout)      state_nx = ST_ERROR;
                    else if (vs_fall) state_nx = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (timeout) begin
                        state_nx = ST_ERROR;
                    end else if (frame_end) begin
                        state_nx = ((frame_err == ERR_NONE) && !count_bad) ? ST_DONE : ST_ERROR;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    state_nx = cont ? ST_WAIT_VS : ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // cap_en follows the next state so writes open on the cycle after addr_clr
    // and close on the same edge that leaves CAPTURE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cap_en <= 1'b0;
        end else begin
            state  <= state_nx;
            cap_en <= (state_nx == ST_CAPTURE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog <= '0;
        end else if (rearm) begin
            wdog <= WD_LOAD;
        end else if (wd_active && !timeout) begin
            wdog <= wdog - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (frame_start) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (state == ST_CAPTURE) begin
            if (hr_rise) begin
                pix_cnt <= '0;
            end else if (pix_take) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (hr_fall && (line_cnt != CNT_MAX)) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    // frame_err decides DONE vs ERROR for the current frame; err_code is the
    // sticky copy the host sees, which survives an ERROR re-arm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= ERR_NONE;
        end else if (frame_start) begin
            frame_err <= ERR_NONE;
        end else if (line_bad) begin
            frame_err <= err_first(frame_err, ERR_LINE_LEN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_code <= ERR_NONE;
        end else if (!abort) begin
            if ((state == ST_IDLE) && cap_req) begin
                err_code <= ERR_NONE;
            end else if (timeout) begin
                err_code <= ERR_TIMEOUT;
            end else if (line_bad && (frame_err == ERR_NONE)) begin
                err_code <= ERR_LINE_LEN;
            end else if (count_bad) begin
                err_code <= ERR_LINE_CNT;
            end else if (state == ST_DONE) begin
                err_code <= ERR_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank      <= 1'b0;
            frame_cnt <= 8'd0;
        end else if ((state == ST_DONE) && !abort) begin
            bank      <= ~bank;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign addr_clr   = frame_start;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE) && !abort;
    assign bank_wr    = bank;
    assign bank_rd    = ~bank;

endmodule
